// File: rtl/reg_mux_pkg.sv
// Shared defaults and shift-mode encodings for the registered N:1 channel mux.
// Pure declarations: no logic, no latency.
// Imported by reg_mux_n_1 and reg_mux_skid.
package reg_mux_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_N_INPUTS = 4;

  // Encoding of the arith input
  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;

  // Select width: ceil(log2(n)), never below one bit
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_mux_skid.sv
// Two-entry result FIFO with valid/ready handshake on both sides.
// Latency 1: a push into an empty buffer is visible at the head next cycle.
// Backpressure: push_ready_o drops at occupancy 2 (registered), and is held low during reset.
module reg_mux_skid
  import reg_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             pop_valid_o,
  input  logic             pop_ready_i
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             push;
  logic             pop;

  // Handshake decode and occupancy next-state; ready depends only on registered count
  always_comb begin
    push_ready_o = (count_q != 2'd2) && !reset;
    pop_valid_o  = (count_q != 2'd0);
    pop_data_o   = mem_q[rd_ptr_q];
    push         = push_valid_i && push_ready_o;
    pop          = pop_valid_o && pop_ready_i;
    count_d      = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointers; reset wipes contents so no stale result survives
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/reg_mux_n_1.sv
// Selects one of N_INPUTS channels, optionally right-shifts it (REG_MUX_SHIFT_EN), buffers the result.
// Latency 1 from accept to out_valid; one transaction per cycle sustained.
// Backpressure: in_ready low while the 2-entry buffer is full or reset is asserted.
module reg_mux_n_1
  import reg_mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int N_INPUTS = DEF_N_INPUTS,
  localparam int SEL_W   = sel_width(N_INPUTS),
  localparam int SH_W    = $clog2(WIDTH) + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic [SH_W-1:0]           shamt,
  input  logic                      arith,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
);

  localparam logic [SEL_W:0] N_SEL = (SEL_W + 1)'(N_INPUTS);

  logic [WIDTH-1:0] chan;
  logic [WIDTH-1:0] result;
  logic             sel_ok;
  logic             accept;
  logic             sel_err_q;
  logic             sel_err_d;

  // Channel select; out-of-range selects read as zero
  always_comb begin
    chan   = '0;
    sel_ok = ({1'b0, sel} < N_SEL);
    for (int k = 0; k < N_INPUTS; k++) begin
      if (sel == SEL_W'(k)) begin
        chan = in_data[k*WIDTH +: WIDTH];
      end
    end
    if (!sel_ok) begin
      chan = '0;
    end
  end

`ifdef REG_MUX_SHIFT_EN
  localparam logic [SH_W-1:0] WIDTH_SH = SH_W'(WIDTH);

  // Right shift, saturating to zero / sign fill once the amount reaches WIDTH
  always_comb begin
    result = '0;
    if (shamt >= WIDTH_SH) begin
      result = (arith == SHIFT_ARITH) ? {WIDTH{chan[WIDTH-1]}} : '0;
    end else if (arith == SHIFT_ARITH) begin
      result = WIDTH'($signed(chan) >>> shamt);
    end else begin
      result = chan >> shamt;
    end
  end
`else
  // Shifter absent: shift controls are accepted but have no effect
  logic unused_shift;
  assign unused_shift = ^{shamt, arith};

  // Pass the selected channel through untouched
  always_comb begin
    result = chan;
  end
`endif

  // Sticky error capture, only on an actual accept
  always_comb begin
    accept    = in_valid && in_ready;
    sel_err_d = sel_err_q || (accept && !sel_ok);
  end

  // Sticky error register, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

  reg_mux_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clock        (clock),
    .reset        (reset),
    .push_data_i  (result),
    .push_valid_i (in_valid),
    .push_ready_o (in_ready),
    .pop_data_o   (out_data),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready)
  );

endmodule

// File: tb/tb_reg_mux_n_1.sv
// Directed bench for reg_mux_n_1: a 4-channel instance plus a 3-channel instance for range errors.
// Expected shift results depend on whether REG_MUX_SHIFT_EN is defined for the build.
// All comparisons go through check(); one summary line at the end.
module tb_reg_mux_n_1;

`ifdef REG_MUX_SHIFT_EN
  localparam bit SHIFT = 1'b1;
`else
  localparam bit SHIFT = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] in_data;
  logic [1:0]   sel;
  logic [5:0]   shamt;
  logic         arith;
  logic         in_valid, in_ready, out_valid, out_ready, sel_err;
  logic [31:0]  out_data;
  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, sel_err_b;
  logic [31:0]  out_data_b;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  reg_mux_n_1 #(.WIDTH(32), .N_INPUTS(4)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .sel(sel), .shamt(shamt),
    .arith(arith), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
  );

  reg_mux_n_1 #(.WIDTH(32), .N_INPUTS(3)) dut3 (
    .clock(clock), .reset(reset), .in_data(in_data[95:0]), .sel(sel), .shamt(shamt),
    .arith(arith), .in_valid(in_valid_b), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .sel_err(sel_err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One isolated transaction: accept, check head next cycle, then let it drain
  task automatic xact(input string tag, input logic [1:0] s, input logic [5:0] sh,
                      input logic ar, input logic [31:0] exp);
    sel = s; shamt = sh; arith = ar; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    check(tag, out_data, exp);
    tick();
  endtask

  initial begin
    reset = 1'b1; in_data = '0; sel = '0; shamt = '0; arith = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_out_data",  out_data, 32'd0);
    check("rst_sel_err",   {31'd0, sel_err},   32'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic select + logical shift
    in_data[2*32 +: 32] = 32'h0000_0100;
    xact("ch2_shr2", 2'd2, 6'd2, 1'b0, SHIFT ? 32'h0000_0040 : 32'h0000_0100);

    // Arithmetic / logical / saturated shifts of a negative value
    in_data[1*32 +: 32] = 32'h8000_0000;
    xact("ch1_sra4",  2'd1, 6'd4,  1'b1, SHIFT ? 32'hF800_0000 : 32'h8000_0000);
    xact("ch1_srl4",  2'd1, 6'd4,  1'b0, SHIFT ? 32'h0800_0000 : 32'h8000_0000);
    xact("ch1_sra40", 2'd1, 6'd40, 1'b1, SHIFT ? 32'hFFFF_FFFF : 32'h8000_0000);
    xact("ch1_srl32", 2'd1, 6'd32, 1'b0, SHIFT ? 32'h0000_0000 : 32'h8000_0000);
    xact("ch1_sra0",  2'd1, 6'd0,  1'b1, 32'h8000_0000);
    check("sel_err_4ch", {31'd0, sel_err}, 32'd0);

    // Out-of-range select on the 3-channel instance
    in_data = {32'h44, 32'h33, 32'h22, 32'h11};
    shamt = '0; arith = 1'b0;
    sel = 2'd3; in_valid_b = 1'b1;
    tick();
    check("bad_sel_data", out_data_b, 32'd0);
    check("bad_sel_err",  {31'd0, sel_err_b}, 32'd1);
    sel = 2'd0;
    for (int i = 0; i < 10; i++) tick();
    in_valid_b = 1'b0;
    check("bad_sel_sticky", {31'd0, sel_err_b}, 32'd1);
    check("good_sel_data",  out_data_b, 32'h11);
    tick();

    // Backpressure: fill, stall, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    tick();
    sel = 2'd1;
    tick();
    sel = 2'd2;
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_head",     out_data, 32'h11);
    tick();
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_head",     out_data, 32'h11);
    out_ready = 1'b1;
    tick();
    check("pop1_head",     out_data, 32'h22);
    check("pop1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("pop2_head", out_data, 32'h33);
    check("pop2_vld",  {31'd0, out_valid}, 32'd1);
    tick();
    check("drained_vld", {31'd0, out_valid}, 32'd0);

    // Streaming: one result per cycle
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 2'(i % 4);
      tick();
      check($sformatf("stream%0d_vld", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("stream%0d", i), out_data, 32'h11 * (32'(i % 4) + 32'd1));
      check($sformatf("stream%0d_rdy", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_vld", {31'd0, out_valid}, 32'd0);

    // Reset with a full buffer
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3;
    tick(); tick();
    in_valid = 1'b0;
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_vld",  {31'd0, out_valid}, 32'd0);
    check("mid_rst_rdy",  {31'd0, in_ready},  32'd0);
    check("mid_rst_data", out_data, 32'd0);
    tick();
    reset = 1'b0; out_ready = 1'b1;
    #1;
    check("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_vld%0d", i), {31'd0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
